rl_fifo_1r1w_ctrl: RTL and testbench

- Synchronous first-word-fall-through FIFO controller that drives an external 1R1W block RAM (registered read data, 1-cycle read latency) on a single clock.
- Owns the write/read pointers, the occupancy count and a 2-entry output prefetch buffer.
- The read side presents valid/ready at full throughput despite RAM read latency.
- Sits directly upstream of the RAM: its ram_* ports connect 1:1 to the RAM wrapper's write/read ports.

---
 rtl/rl_fifo_pkg.sv | 12 +
 rtl/rl_fifo_oq.sv | 53 +++++
 rtl/rl_fifo_1r1w_ctrl.sv | 105 ++++++++++
 tb/tb_rl_fifo_1r1w_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rl_fifo_pkg.sv
// Shared types and sizing helpers for the rl_fifo FWFT controller.
package rl_fifo_pkg;

    localparam int OQ_DEPTH = 2;

    typedef logic [1:0] oq_cnt_t;

    function automatic int rl_fifo_lvl_w(input int abits);
        return abits + 2;
    endfunction

endpackage

// File: rtl/rl_fifo_oq.sv
// Two-entry output prefetch buffer; head is oq[0], registered count/data.
// Capture lands behind any surviving entry; a pop shifts the buffer by one.
module rl_fifo_oq
    import rl_fifo_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             cap_i,
    input  logic [DBITS-1:0] cap_dat_i,
    input  logic             pop_i,
    output logic [DBITS-1:0] head_o,
    output logic             vld_o,
    output logic [1:0]       cnt_o
);

    logic [DBITS-1:0] mem_q [OQ_DEPTH];
    logic [DBITS-1:0] mem_d [OQ_DEPTH];
    oq_cnt_t          cnt_q, cnt_d, wr_idx;

    always_comb begin
        mem_d  = mem_q;
        wr_idx = cnt_q - oq_cnt_t'(pop_i);
        if (pop_i) begin
            mem_d[0] = mem_q[1];
        end
        // The upstream issue rule guarantees wr_idx never exceeds 1 here.
        if (cap_i) begin
            if (wr_idx == 2'd0) mem_d[0] = cap_dat_i;
            else                mem_d[1] = cap_dat_i;
        end
        cnt_d = cnt_q - oq_cnt_t'(pop_i) + oq_cnt_t'(cap_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o = mem_q[0];
    assign vld_o  = (cnt_q != 2'd0);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/rl_fifo_1r1w_ctrl.sv
// FWFT controller for a 1-cycle-latency 1R1W RAM: push to rvalid_o is 3 cycles, 1 pop/cycle once primed.
// Pushes while full are dropped; RL_FIFO_OVERFLOW_EN adds a sticky ovf_o flag for them.
module rl_fifo_1r1w_ctrl
    import rl_fifo_pkg::*;
#(
    parameter int ABITS = 4,
    parameter int DBITS = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic                            push_i,
    input  logic [DBITS-1:0]                wdata_i,
    output logic                            full_o,
    output logic [DBITS-1:0]                rdata_o,
    output logic                            rvalid_o,
    input  logic                            rready_i,
    output logic [rl_fifo_lvl_w(ABITS)-1:0] level_o,
    output logic [ABITS-1:0]                ram_waddr_o,
    output logic [DBITS-1:0]                ram_din_o,
    output logic                            ram_we_o,
    output logic [(DBITS+7)/8-1:0]          ram_be_o,
    output logic [ABITS-1:0]                ram_raddr_o,
`ifdef RL_FIFO_OVERFLOW_EN
    output logic                            ovf_o,
`endif
    input  logic [DBITS-1:0]                ram_dout_i
);

    localparam int LW = rl_fifo_lvl_w(ABITS);
    localparam int CW = ABITS + 1;
    localparam logic [CW-1:0] DEPTH = CW'(2**ABITS);

    logic [ABITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
    logic             rd_pend_q;
    logic [LW-1:0]    level_q, level_d;
    logic [1:0]       oq_cnt;
    logic [2:0]       oq_need;
    logic             wr, rd, pop, cap;

    assign full_o  = (ram_cnt_q == DEPTH);
    assign pop     = rvalid_o & rready_i & ~clear_i;
    assign wr      = push_i & ~full_o & ~clear_i;
    assign oq_need = {1'b0, oq_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};
    // Only issue a read if the buffer will have room when the data returns.
    assign rd      = (ram_cnt_q != '0) & (oq_need < 3'd2) & ~clear_i;
    assign cap     = rd_pend_q & ~clear_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + ABITS'(wr);
        rd_ptr_d  = rd_ptr_q + ABITS'(rd);
        ram_cnt_d = ram_cnt_q + CW'(wr) - CW'(rd);
        level_d   = level_q + LW'(wr) - LW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            level_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            rd_pend_q <= rd;
            level_q   <= level_d;
        end
    end

`ifdef RL_FIFO_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) ovf_q <= 1'b0;
        else if (push_i && full_o) ovf_q <= 1'b1;
    end

    assign ovf_o = ovf_q;
`endif

    rl_fifo_oq #(
        .DBITS (DBITS)
    ) u_oq (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .cap_i     (cap),
        .cap_dat_i (ram_dout_i),
        .pop_i     (pop),
        .head_o    (rdata_o),
        .vld_o     (rvalid_o),
        .cnt_o     (oq_cnt)
    );

    assign level_o     = level_q;
    assign ram_we_o    = wr;
    assign ram_waddr_o = wr_ptr_q;
    assign ram_din_o   = wdata_i;
    assign ram_be_o    = '1;
    assign ram_raddr_o = rd_ptr_q;

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// Directed bench for rl_fifo_1r1w_ctrl (ABITS=2) with a 1-cycle-latency RAM model.
module tb_rl_fifo_1r1w_ctrl;

    localparam int ABITS = 2;
    localparam int DBITS = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              push;
    logic [DBITS-1:0]  wdata;
    logic              full;
    logic [DBITS-1:0]  rdata;
    logic              rvalid;
    logic              rready;
    logic [ABITS+1:0]  level;
    logic [ABITS-1:0]  ram_waddr;
    logic [DBITS-1:0]  ram_din;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ABITS-1:0]  ram_raddr;
    logic [DBITS-1:0]  ram_dout;
`ifdef RL_FIFO_OVERFLOW_EN
    logic              ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int got;

    logic [DBITS-1:0] ram_mem [4];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_waddr] <= ram_din;
        ram_dout <= ram_mem[ram_raddr];
    end

    rl_fifo_1r1w_ctrl #(
        .ABITS (ABITS),
        .DBITS (DBITS)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .push_i      (push),
        .wdata_i     (wdata),
        .full_o      (full),
        .rdata_o     (rdata),
        .rvalid_o    (rvalid),
        .rready_i    (rready),
        .level_o     (level),
        .ram_waddr_o (ram_waddr),
        .ram_din_o   (ram_din),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_raddr_o (ram_raddr),
`ifdef RL_FIFO_OVERFLOW_EN
        .ovf_o       (ovf),
`endif
        .ram_dout_i  (ram_dout)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ram_mem[i] = '0;
        ram_dout = '0;
        rst_n = 1'b0; clear = 1'b0; push = 1'b0; wdata = '0; rready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Reset state and idle
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("idle_full", full, 0);
            chk("idle_rvalid", rvalid, 0);
            chk("idle_level", level, 0);
            chk("idle_we", ram_we, 0);
            step();
        end
        chk("rst_rdata", rdata, 0);
        chk("rst_raddr", ram_raddr, 0);
        chk("rst_be", ram_be, 4'hF);

        // Single push latency and hold
        push = 1'b1; wdata = 32'h11; #1;
        chk("lat_we", ram_we, 1);
        chk("lat_waddr", ram_waddr, 0);
        step();
        push = 1'b0; #1;
        chk("lat_c1_rvalid", rvalid, 0);
        chk("lat_c1_level", level, 1);
        step(); #1;
        chk("lat_c2_rvalid", rvalid, 0);
        step(); #1;
        for (int c = 0; c < 5; c++) begin
            chk("hold_rvalid", rvalid, 1);
            chk("hold_rdata", rdata, 32'h11);
            chk("hold_level", level, 1);
            step(); #1;
        end
        rready = 1'b1;
        step();
        rready = 1'b0; #1;
        chk("pop1_rvalid", rvalid, 0);
        chk("pop1_level", level, 0);

        // Fill past capacity with consumer stalled
        for (int k = 0; k < 8; k++) begin
            push = 1'b1; wdata = 32'(k + 1); #1;
            chk("fill_full", full, (k >= 6) ? 64'd1 : 64'd0);
            chk("fill_we", ram_we, (k >= 6) ? 64'd0 : 64'd1);
            step();
        end
        push = 1'b0; #1;
        chk("fill_level", level, 6);
        chk("fill_full_end", full, 1);
`ifdef RL_FIFO_OVERFLOW_EN
        chk("fill_ovf", ovf, 1);
`endif
        rready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            #1;
            if (rvalid) begin
                chk("fill_data", rdata, 64'(got + 1));
                got++;
            end
            step();
        end
        rready = 1'b0; #1;
        chk("fill_pops", got, 6);
        chk("fill_empty_rvalid", rvalid, 0);
        chk("fill_empty_level", level, 0);

        // Streaming with consumer always ready
        rready = 1'b1;
        got = 0;
        for (int c = 0; c < 200 && got < 64; c++) begin
            push = (c < 64); wdata = 32'h100 + 32'(c); #1;
            chk("cont_level_le3", level <= 3, 1);
            if (got > 0) chk("cont_nobubble", rvalid, 1);
            if (rvalid) begin
                chk("cont_data", rdata, 64'h100 + 64'(got));
                got++;
            end
            step();
        end
        push = 1'b0; rready = 1'b0; #1;
        chk("cont_pops", got, 64);
        chk("cont_empty_level", level, 0);

        // Fill then toggle rready
        for (int k = 0; k < 6; k++) begin
            push = 1'b1; wdata = 32'(k + 1);
            step();
        end
        push = 1'b0; #1;
        chk("tog_full", full, 1);
        chk("tog_level", level, 6);
        got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            rready = (c % 2 == 0); #1;
            if (rready && rvalid) begin
                chk("tog_data", rdata, 64'(got + 1));
                got++;
            end
            step();
        end
        rready = 1'b0;
        repeat (3) step();
        #1;
        chk("tog_pops", got, 6);
        chk("tog_empty_rvalid", rvalid, 0);
        chk("tog_empty_level", level, 0);

        // Clear with a simultaneous push
        for (int k = 0; k < 4; k++) begin
            push = 1'b1; wdata = 32'h21 + 32'(k);
            step();
        end
        push = 1'b1; wdata = 32'h55; clear = 1'b1;
        step();
        push = 1'b0; clear = 1'b0; #1;
        chk("clr_level", level, 0);
        chk("clr_rvalid", rvalid, 0);
        chk("clr_full", full, 0);
`ifdef RL_FIFO_OVERFLOW_EN
        chk("clr_ovf", ovf, 0);
`endif
        step();
        push = 1'b1; wdata = 32'hAA; #1;
        chk("clr_we", ram_we, 1);
        chk("clr_waddr", ram_waddr, 0);
        step();
        push = 1'b0;
        step(); #1;
        chk("clr_c2_rvalid", rvalid, 0);
        step(); #1;
        chk("clr_c3_rvalid", rvalid, 1);
        chk("clr_c3_rdata", rdata, 32'hAA);
        chk("clr_c3_level", level, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
